// File: rtl/rmgmt_mem_seq_if.sv
// Bundle of the extension-side request signals and the core data-bus signals
// for rmgmt_mem_seq. The slave modport is the sequencer's view; the master
// modport is the view of whatever drives requests and models the bus.
//
// Handshake: a request is taken in the IDLE cycle where req_mem is high with a
// legal op and aligned address. mem_busy is high in that cycle and until the
// bus access has finished. The bus side completes a strobe in the first cycle
// where bus_busy is low. bus_rdata is only looked at in that cycle.
interface rmgmt_mem_seq_if;
  logic        req_mem;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic        flush;
  logic [31:0] mem_load;
  logic        mem_busy;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic        bus_busy;
  logic [31:0] bus_rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [1:0]  state_dbg;

  modport slave (
    input  req_mem, mem_ren, mem_wen, mem_addr, mem_store, flush,
    input  bus_busy, bus_rdata,
    output mem_load, mem_busy, bus_addr, bus_wdata, bus_ren, bus_wen,
    output fault, fault_cause, state_dbg
  );

  modport master (
    output req_mem, mem_ren, mem_wen, mem_addr, mem_store, flush,
    output bus_busy, bus_rdata,
    input  mem_load, mem_busy, bus_addr, bus_wdata, bus_ren, bus_wen,
    input  fault, fault_cause, state_dbg
  );
endinterface

// File: rtl/rmgmt_mem_seq.sv
// rmgmt_mem_seq: sequences one data-memory access for a RISC-MGMT extension
// onto the core data bus. IDLE -> ACCESS (strobe held until bus_busy drops)
// -> DONE (one cycle) -> IDLE. Misaligned or illegal requests are rejected
// with a one-cycle fault pulse. A flush in ACCESS lets the bus access finish
// but discards its result and skips DONE.
//
// Optional feature: define RMGMT_MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES busy cycles in ACCESS (fault cause 3). Without it, ACCESS
// waits for the bus indefinitely.
module rmgmt_mem_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RST,
  rmgmt_mem_seq_if.slave   m
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

  // Elaboration-time guard on the abort limit; the counter is 8 bits wide.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rmgmt_mem_seq: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        op_load_q;   // 1 = load, 0 = store
  logic        kill_q;      // flush seen during ACCESS, drop the result
  logic [31:0] load_q;
  logic        fault_q;
  logic [1:0]  cause_q;
  logic        valid_start;
  logic        one_op;

`ifdef RMGMT_MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] CAUSE_TOUT = 2'd3;
  logic [7:0] tout_cnt;
`endif

  // Exactly one of load/store requested, address word aligned, not killed.
  always_comb begin
    one_op      = m.mem_ren ^ m.mem_wen;
    valid_start = (state == IDLE) && m.req_mem && one_op &&
                  (m.mem_addr[1:0] == 2'b00) && !m.flush;
  end

  // Stall the extension from the accepting cycle through the last ACCESS cycle.
  assign m.mem_busy    = valid_start || (state == ACCESS);
  assign m.bus_ren     = (state == ACCESS) && op_load_q;
  assign m.bus_wen     = (state == ACCESS) && !op_load_q;
  // Latched address is word aligned, so it is also the bus word address.
  assign m.bus_addr    = addr_q;
  assign m.bus_wdata   = data_q;
  assign m.mem_load    = load_q;
  assign m.fault       = fault_q;
  assign m.fault_cause = cause_q;
  assign m.state_dbg   = state;

  // Sequencer FSM with registered load data and fault pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      op_load_q <= 1'b0;
      kill_q    <= 1'b0;
      load_q    <= 32'd0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
`ifdef RMGMT_MEM_TIMEOUT_EN
      tout_cnt  <= 8'd0;
`endif
    end else begin
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      case (state)
        IDLE: begin
          if (m.req_mem && !m.flush) begin
            if (m.mem_ren && m.mem_wen) begin
              // Illegal op wins over misalignment.
              fault_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (one_op) begin
              if (m.mem_addr[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                cause_q <= CAUSE_MISALIGN;
              end else begin
                addr_q    <= m.mem_addr;
                data_q    <= m.mem_store;
                op_load_q <= m.mem_ren;
                kill_q    <= 1'b0;
                state     <= ACCESS;
`ifdef RMGMT_MEM_TIMEOUT_EN
                tout_cnt  <= 8'd0;
`endif
              end
            end
          end
        end
        ACCESS: begin
          if (!m.bus_busy) begin
            kill_q <= 1'b0;
            if (kill_q || m.flush) begin
              state <= IDLE;
            end else begin
              if (op_load_q) begin
                load_q <= m.bus_rdata;
              end
              state <= DONE;
            end
          end else begin
            if (m.flush) begin
              kill_q <= 1'b1;
            end
`ifdef RMGMT_MEM_TIMEOUT_EN
            tout_cnt <= tout_cnt + 8'd1;
            if (tout_cnt + 8'd1 == TO_LIMIT) begin
              state   <= IDLE;
              kill_q  <= 1'b0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_TOUT;
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmgmt_mem_seq.sv
// Directed bench for rmgmt_mem_seq. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later, well away from the edge.
module tb_rmgmt_mem_seq;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  rmgmt_mem_seq_if mif ();

  rmgmt_mem_seq #(.TIMEOUT_CYCLES(4)) dut (
    .CLK (clk),
    .RST (rst),
    .m   (mif)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif.req_mem   = 1'b0;
    mif.mem_ren   = 1'b0;
    mif.mem_wen   = 1'b0;
    mif.mem_addr  = 32'd0;
    mif.mem_store = 32'd0;
    mif.flush     = 1'b0;
    mif.bus_busy  = 1'b0;
    mif.bus_rdata = 32'd0;
  endtask

  // Driver: present one request for the current cycle.
  task automatic drive_req(input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] data);
    mif.req_mem   = 1'b1;
    mif.mem_ren   = ren;
    mif.mem_wen   = wen;
    mif.mem_addr  = addr;
    mif.mem_store = data;
  endtask

  task automatic drop_req();
    mif.req_mem = 1'b0;
    mif.mem_ren = 1'b0;
    mif.mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    total++; if (mif.state_dbg !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", mif.state_dbg, S_IDLE); else passed++;
    total++; if (mif.mem_load !== 32'd0) $display("FAIL reset_load: got %h want 0", mif.mem_load); else passed++;
    total++; if ({mif.fault, mif.fault_cause} !== 3'b000) $display("FAIL reset_fault: got %b want 000", {mif.fault, mif.fault_cause}); else passed++;
    total++; if ({mif.mem_busy, mif.bus_ren, mif.bus_wen} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {mif.mem_busy, mif.bus_ren, mif.bus_wen}); else passed++;
    total++; if (mif.bus_addr !== 32'd0) $display("FAIL reset_addr: got %h want 0", mif.bus_addr); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    // Cycle N
    drive_req(1'b1, 1'b0, 32'h100, 32'h0);
    mif.bus_busy  = 1'b0;
    mif.bus_rdata = 32'hDEADBEEF;
    #1;
    total++; if ({mif.mem_busy, mif.bus_ren} !== 2'b10) $display("FAIL load_n: busy/ren got %b want 10", {mif.mem_busy, mif.bus_ren}); else passed++;
    tick(); // N+1
    drop_req();
    #1;
    total++; if ({mif.mem_busy, mif.bus_ren, mif.bus_wen} !== 3'b110) $display("FAIL load_n1_strobe: got %b want 110", {mif.mem_busy, mif.bus_ren, mif.bus_wen}); else passed++;
    total++; if (mif.bus_addr !== 32'h100) $display("FAIL load_addr: got %h want 00000100", mif.bus_addr); else passed++;
    tick(); // N+2
    total++; if (mif.mem_load !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", mif.mem_load); else passed++;
    total++; if ({mif.mem_busy, mif.bus_ren} !== 2'b00) $display("FAIL load_n2_busy: got %b want 00", {mif.mem_busy, mif.bus_ren}); else passed++;
    total++; if (mif.state_dbg !== S_DONE) $display("FAIL load_done: got %0d want %0d", mif.state_dbg, S_DONE); else passed++;
    tick();
    total++; if (mif.state_dbg !== S_IDLE) $display("FAIL load_idle: got %0d want %0d", mif.state_dbg, S_IDLE); else passed++;
  endtask

  task automatic test_store();
    int wen_cycles;
    int busy_cycles;
    logic wdata_ok;
    wen_cycles  = 0;
    busy_cycles = 0;
    wdata_ok    = 1'b1;
    drive_req(1'b0, 1'b1, 32'h204, 32'h12345678);
    mif.bus_busy  = 1'b1;
    mif.bus_rdata = 32'hBAD0BAD0;
    #1;
    if (mif.mem_busy) busy_cycles++;
    for (int i = 0; i < 4; i++) begin
      tick();
      drop_req();
      mif.bus_busy = (i < 3);
      #1;
      if (mif.bus_wen) wen_cycles++;
      if (mif.bus_wdata !== 32'h12345678) wdata_ok = 1'b0;
      if (mif.mem_busy) busy_cycles++;
    end
    tick();
    if (mif.bus_wen) wen_cycles++;
    if (mif.mem_busy) busy_cycles++;
    total++; if (wen_cycles !== 4) $display("FAIL store_wen_len: got %0d want 4", wen_cycles); else passed++;
    total++; if (wdata_ok !== 1'b1) $display("FAIL store_wdata: got bad data want 12345678"); else passed++;
    // Accept cycle plus four ACCESS cycles.
    total++; if (busy_cycles !== 5) $display("FAIL store_busy_len: got %0d want 5", busy_cycles); else passed++;
    total++; if (mif.mem_load !== 32'hDEADBEEF) $display("FAIL store_load_kept: got %h want deadbeef", mif.mem_load); else passed++;
    mif.bus_busy = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    drive_req(1'b1, 1'b0, 32'h102, 32'h0);
    #1;
    total++; if ({mif.mem_busy, mif.bus_ren} !== 2'b00) $display("FAIL misalign_busy: got %b want 00", {mif.mem_busy, mif.bus_ren}); else passed++;
    tick();
    drop_req();
    #1;
    total++; if ({mif.fault, mif.fault_cause} !== 3'b101) $display("FAIL misalign_fault: got %b want 101", {mif.fault, mif.fault_cause}); else passed++;
    total++; if ({mif.mem_busy, mif.bus_ren, mif.state_dbg} !== 4'b0000) $display("FAIL misalign_nostart: got %b want 0000", {mif.mem_busy, mif.bus_ren, mif.state_dbg}); else passed++;
    tick();
    total++; if ({mif.fault, mif.fault_cause} !== 3'b000) $display("FAIL fault_pulse_len: got %b want 000", {mif.fault, mif.fault_cause}); else passed++;
    // Both ren and wen on a misaligned address: illegal op wins.
    drive_req(1'b1, 1'b1, 32'h102, 32'h0);
    tick();
    drop_req();
    #1;
    total++; if ({mif.fault, mif.fault_cause} !== 3'b110) $display("FAIL illegal_fault: got %b want 110", {mif.fault, mif.fault_cause}); else passed++;
    total++; if ({mif.bus_ren, mif.bus_wen} !== 2'b00) $display("FAIL illegal_nostrobe: got %b want 00", {mif.bus_ren, mif.bus_wen}); else passed++;
    tick();
    // Neither op set: silently ignored.
    drive_req(1'b0, 1'b0, 32'h103, 32'h0);
    tick();
    drop_req();
    #1;
    total++; if ({mif.fault, mif.state_dbg} !== 3'b000) $display("FAIL noop_ignored: got %b want 000", {mif.fault, mif.state_dbg}); else passed++;
    // Flush in IDLE suppresses both a good start and a fault.
    drive_req(1'b1, 1'b0, 32'h100, 32'h0);
    mif.flush = 1'b1;
    #1;
    total++; if (mif.mem_busy !== 1'b0) $display("FAIL flush_idle_busy: got %b want 0", mif.mem_busy); else passed++;
    tick();
    drive_req(1'b1, 1'b1, 32'h101, 32'h0);
    tick();
    drop_req();
    mif.flush = 1'b0;
    #1;
    total++; if ({mif.fault, mif.state_dbg} !== 3'b000) $display("FAIL flush_idle_nofault: got %b want 000", {mif.fault, mif.state_dbg}); else passed++;
    tick();
  endtask

  task automatic test_flush_access();
    drive_req(1'b1, 1'b0, 32'h300, 32'h0);
    mif.bus_busy  = 1'b1;
    mif.bus_rdata = 32'hCAFEF00D;
    tick(); // first ACCESS cycle
    drop_req();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    #1;
    total++; if ({mif.bus_ren, mif.mem_busy} !== 2'b11) $display("FAIL flush_hold1: got %b want 11", {mif.bus_ren, mif.mem_busy}); else passed++;
    tick();
    mif.bus_busy = 1'b0;
    #1;
    total++; if ({mif.bus_ren, mif.mem_busy} !== 2'b11) $display("FAIL flush_hold2: got %b want 11", {mif.bus_ren, mif.mem_busy}); else passed++;
    tick();
    total++; if (mif.state_dbg !== S_IDLE) $display("FAIL flush_skip_done: got %0d want %0d", mif.state_dbg, S_IDLE); else passed++;
    total++; if (mif.mem_load !== 32'hDEADBEEF) $display("FAIL flush_load_kept: got %h want deadbeef", mif.mem_load); else passed++;
    total++; if ({mif.mem_busy, mif.bus_ren, mif.fault} !== 3'b000) $display("FAIL flush_end: got %b want 000", {mif.mem_busy, mif.bus_ren, mif.fault}); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 1'b0, 32'h10, 32'h0);
    mif.bus_busy  = 1'b0;
    mif.bus_rdata = 32'h0000_1111;
    tick(); // ACCESS
    tick(); // DONE, request still held
    mif.bus_rdata = 32'h0000_2222;
    drive_req(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    total++; if ({mif.state_dbg, mif.mem_busy} !== {S_DONE, 1'b0}) $display("FAIL b2b_done_ignores: got %b want 100", {mif.state_dbg, mif.mem_busy}); else passed++;
    total++; if (mif.mem_load !== 32'h0000_1111) $display("FAIL b2b_first: got %h want 00001111", mif.mem_load); else passed++;
    tick(); // IDLE gap cycle accepts the second request
    #1;
    total++; if (mif.mem_busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", mif.mem_busy); else passed++;
    tick();
    drop_req();
    #1;
    total++; if (mif.bus_addr !== 32'h20) $display("FAIL b2b_addr: got %h want 00000020", mif.bus_addr); else passed++;
    tick();
    total++; if (mif.mem_load !== 32'h0000_2222) $display("FAIL b2b_second: got %h want 00002222", mif.mem_load); else passed++;
    tick();
  endtask

  task automatic test_reset_access();
    drive_req(1'b1, 1'b0, 32'h80, 32'h0);
    mif.bus_busy = 1'b1;
    tick();
    drop_req();
    #1;
    total++; if (mif.bus_ren !== 1'b1) $display("FAIL rst_mid_pre: got %b want 1", mif.bus_ren); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mif.bus_busy = 1'b0;
    #1;
    total++; if ({mif.bus_ren, mif.bus_wen, mif.fault, mif.state_dbg} !== 5'b00000) $display("FAIL rst_mid_post: got %b want 00000", {mif.bus_ren, mif.bus_wen, mif.fault, mif.state_dbg}); else passed++;
    total++; if (mif.mem_load !== 32'd0) $display("FAIL rst_mid_load: got %h want 0", mif.mem_load); else passed++;
    drive_req(1'b1, 1'b0, 32'h40, 32'h0);
    mif.bus_rdata = 32'h55AA55AA;
    tick();
    drop_req();
    tick();
    total++; if ({mif.mem_load, mif.mem_busy} !== {32'h55AA55AA, 1'b0}) $display("FAIL rst_then_load: got %h/%b want 55aa55aa/0", mif.mem_load, mif.mem_busy); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int ren_cycles;
    ren_cycles = 0;
    drive_req(1'b1, 1'b0, 32'h500, 32'h0);
    mif.bus_busy = 1'b1;
    tick();
    drop_req();
`ifdef RMGMT_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mif.bus_ren) ren_cycles++;
      tick();
    end
    total++; if (ren_cycles !== 4) $display("FAIL tout_strobe_len: got %0d want 4", ren_cycles); else passed++;
    total++; if ({mif.bus_ren, mif.mem_busy, mif.state_dbg} !== 4'b0000) $display("FAIL tout_abort: got %b want 0000", {mif.bus_ren, mif.mem_busy, mif.state_dbg}); else passed++;
    total++; if ({mif.fault, mif.fault_cause} !== 3'b111) $display("FAIL tout_fault: got %b want 111", {mif.fault, mif.fault_cause}); else passed++;
    total++; if (mif.mem_load !== 32'h55AA55AA) $display("FAIL tout_load_kept: got %h want 55aa55aa", mif.mem_load); else passed++;
    mif.bus_busy = 1'b0;
    tick();
`else
    for (int i = 0; i < 120; i++) begin
      #1;
      if (mif.mem_busy && mif.bus_ren && !mif.fault) ren_cycles++;
      tick();
    end
    total++; if (ren_cycles !== 120) $display("FAIL no_tout_wait: got %0d want 120", ren_cycles); else passed++;
    mif.bus_busy  = 1'b0;
    mif.bus_rdata = 32'h0BADCAFE;
    tick();
    total++; if ({mif.state_dbg, mif.mem_load} !== {S_DONE, 32'h0BADCAFE}) $display("FAIL no_tout_finish: got %0d/%h want 2/0badcafe", mif.state_dbg, mif.mem_load); else passed++;
    tick();
`endif
  endtask

  // Sequence of scenarios and final report
  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_store();
    test_faults();
    test_flush_access();
    test_back_to_back();
    test_reset_access();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
